// File: rtl/vm_pkg.sv
// Shared vending-controller definitions: coin codes, FSM states, coin values and default prices.
package vm_pkg;
    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_5    = 2'd1;
    localparam logic [1:0] COIN_10   = 2'd2;
    localparam logic [1:0] COIN_20   = 2'd3;

    localparam int unsigned DEF_PRICE0 = 3;
    localparam int unsigned DEF_PRICE1 = 2;
    localparam int unsigned DEF_PRICE2 = 4;
    localparam int unsigned DEF_PRICE3 = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_DISPENSE,
        ST_CHANGE
    } vm_state_e;

    // Coin value in 5-unit steps.
    function automatic logic [2:0] coin_value(input logic [1:0] coin);
        logic [2:0] v;
        case (coin)
            COIN_5:  v = 3'd1;
            COIN_10: v = 3'd2;
            COIN_20: v = 3'd4;
            default: v = 3'd0;
        endcase
        return v;
    endfunction
endpackage

// File: rtl/vm_change_gen.sv
// Change payout: holds the remainder and serializes it as greedy 10/5 coins over a valid/ack handshake.
module vm_change_gen
    import vm_pkg::*;
#(
    parameter int unsigned CREDIT_W = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load_i,
    input  logic [CREDIT_W-1:0] load_val_i,
    input  logic                run_i,
    input  logic                chg_ack_i,
    output logic                chg_valid_o,
    output logic [1:0]          chg_coin_o,
    output logic [CREDIT_W-1:0] rem_o,
    output logic                done_o
);
    logic [CREDIT_W-1:0] rem_q, rem_d;
    logic [CREDIT_W-1:0] step;
    logic                take;

    assign step        = (rem_q >= CREDIT_W'(2)) ? CREDIT_W'(2) : CREDIT_W'(1);
    assign chg_valid_o = run_i && (rem_q != '0);
    assign chg_coin_o  = !chg_valid_o ? COIN_NONE : ((rem_q >= CREDIT_W'(2)) ? COIN_10 : COIN_5);
    assign take        = chg_valid_o && chg_ack_i;
    // done fires on the ack of the last coin so the controller leaves CHANGE the same edge
    assign done_o      = take && (rem_q == step);
    assign rem_o       = rem_q;

    always_comb begin
        rem_d = rem_q;
        if (load_i) begin
            rem_d = load_val_i;
        end else if (take) begin
            rem_d = rem_q - step;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end
endmodule

// File: rtl/vm_vend_ctrl.sv
// Vending controller: credit accumulation, price check, dispense handshake and change payout.
// Optional idle auto-refund in CREDIT is enabled by defining VM_TIMEOUT_EN.
module vm_vend_ctrl
    import vm_pkg::*;
#(
    parameter int unsigned CREDIT_W    = 6,
    parameter int unsigned PRICE0      = DEF_PRICE0,
    parameter int unsigned PRICE1      = DEF_PRICE1,
    parameter int unsigned PRICE2      = DEF_PRICE2,
    parameter int unsigned PRICE3      = DEF_PRICE3,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          in,
    input  logic                sel_valid,
    input  logic [1:0]          sel,
    input  logic                cancel,
    output logic                disp_req,
    output logic [1:0]          disp_id,
    input  logic                disp_ack,
    output logic                chg_valid,
    output logic [1:0]          chg_coin,
    input  logic                chg_ack,
    output logic                coin_reject,
    output logic                low_credit,
    output logic [CREDIT_W-1:0] credit
);
    typedef logic [CREDIT_W:0] wide_t;
    localparam wide_t MAX_CREDIT = wide_t'((1 << CREDIT_W) - 1);

    vm_state_e           state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [1:0]          sel_q, sel_d;
    logic                reject_q, reject_d;
    logic                low_q, low_d;
    logic                has_coin, enough, timeout;
    wide_t               coin_w, price, sum_coin, rem_base, rem_coin;
    logic                load;
    logic [CREDIT_W-1:0] load_val;
    logic [CREDIT_W-1:0] rem;
    logic                chg_done;

    assign has_coin = (in != COIN_NONE);
    assign coin_w   = wide_t'(coin_value(in));
    assign sum_coin = {1'b0, credit_q} + coin_w;
    assign enough   = ({1'b0, credit_q} >= price);
    assign rem_base = {1'b0, credit_q} - price;
    assign rem_coin = rem_base + coin_w;

    always_comb begin
        case (sel)
            2'd0:    price = wide_t'(PRICE0);
            2'd1:    price = wide_t'(PRICE1);
            2'd2:    price = wide_t'(PRICE2);
            default: price = wide_t'(PRICE3);
        endcase
    end

`ifdef VM_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            activity;

    assign activity = has_coin || sel_valid || cancel;
    assign timeout  = (state_q == ST_CREDIT) && !activity && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock) begin
        if (!reset || state_q != ST_CREDIT || activity) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        sel_d    = sel_q;
        reject_d = 1'b0;
        low_d    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        case (state_q)
            ST_IDLE: begin
                if (has_coin) begin
                    if (sum_coin <= MAX_CREDIT) begin
                        credit_d = sum_coin[CREDIT_W-1:0];
                        state_d  = ST_CREDIT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ST_CREDIT: begin
                if (cancel || timeout) begin
                    // a coin arriving with a refund is handed straight back
                    reject_d = has_coin;
                    credit_d = '0;
                    load     = 1'b1;
                    load_val = credit_q;
                    state_d  = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end else if (sel_valid && enough) begin
                    sel_d    = sel;
                    credit_d = '0;
                    load     = 1'b1;
                    state_d  = ST_DISPENSE;
                    if (has_coin && rem_coin <= MAX_CREDIT) begin
                        load_val = rem_coin[CREDIT_W-1:0];
                    end else begin
                        load_val = rem_base[CREDIT_W-1:0];
                        reject_d = has_coin;
                    end
                end else begin
                    low_d = sel_valid;
                    if (has_coin) begin
                        if (sum_coin <= MAX_CREDIT) begin
                            credit_d = sum_coin[CREDIT_W-1:0];
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                end
            end
            ST_DISPENSE: begin
                reject_d = has_coin;
                if (disp_ack) begin
                    state_d = (rem != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                reject_d = has_coin;
                if (chg_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            sel_q    <= '0;
            reject_q <= 1'b0;
            low_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            sel_q    <= sel_d;
            reject_q <= reject_d;
            low_q    <= low_d;
        end
    end

    vm_change_gen #(.CREDIT_W(CREDIT_W)) u_change (
        .clock       (clock),
        .reset       (reset),
        .load_i      (load),
        .load_val_i  (load_val),
        .run_i       (state_q == ST_CHANGE),
        .chg_ack_i   (chg_ack),
        .chg_valid_o (chg_valid),
        .chg_coin_o  (chg_coin),
        .rem_o       (rem),
        .done_o      (chg_done)
    );

    assign disp_req    = (state_q == ST_DISPENSE);
    assign disp_id     = disp_req ? sel_q : 2'd0;
    assign coin_reject = reject_q;
    assign low_credit  = low_q;

    always_comb begin
        case (state_q)
            ST_IDLE, ST_CREDIT: credit = credit_q;
            ST_CHANGE:          credit = rem;
            default:            credit = '0;
        endcase
    end
endmodule
